ysyx_22051013_icache_ctrl: RTL and testbench



---
 rtl/ysyx_22051013_icache_ctrl_if.sv | 34 +++
 rtl/ysyx_22051013_icache_ctrl.sv | 146 ++++++++++++++
 tb/tb_ysyx_22051013_icache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_icache_ctrl_if.sv
// Fetch, refill-bus and data-RAM signals of the instruction cache controller.
// slave is the controller's view; master is the view of the surrounding IF stage, memory and RAM.
interface ysyx_22051013_icache_ctrl_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LINE_W  = 64;
    localparam int unsigned IDX_W   = 5;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_data;
    logic              flush;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;
    logic [IDX_W-1:0]  ram_addr;
    logic [LINE_W-1:0] ram_wdata;
    logic              ram_we;
    logic [LINE_W-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data, ram_rdata,
        output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data, ram_rdata,
        input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/ysyx_22051013_icache_ctrl.sv
// Direct-mapped 32 x 8-byte read-only icache controller: tag/valid flops, hit check, refill, fence.i flush.
// Define YSYX_22051013_ICACHE_STAT_EN to add the hit_cnt/miss_cnt statistics ports.
module ysyx_22051013_icache_ctrl (
    input  logic clk,
    input  logic rst_n,
    ysyx_22051013_icache_ctrl_if.slave bus
`ifdef YSYX_22051013_ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int unsigned LINES  = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned TAG_W  = 24;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_WAIT = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [31:2]        addr_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic               flush_pending_q;

    logic [IDX_W-1:0]   idx_c;
    logic [TAG_W-1:0]   tag_c;
    logic               hit_c;
    logic               ready_c;
    logic               accept_c;
    logic               refill_c;
    logic               flush_clr_c;

    assign idx_c       = addr_q[7:3];
    assign tag_c       = addr_q[31:8];
    assign hit_c       = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    assign refill_c    = (state_q == MISS_WAIT) && bus.mem_resp_valid;
    assign flush_clr_c = (state_q == IDLE) && flush_pending_q;

    // A pending or arriving flush blocks new fetches so fence.i cannot be starved by a hit stream.
    assign ready_c  = !flush_pending_q && !bus.flush &&
                      ((state_q == IDLE) || ((state_q == LOOKUP) && hit_c));
    assign accept_c = bus.req_valid && ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept_c) state_d = LOOKUP;
            LOOKUP: begin
                if (!hit_c)        state_d = MISS_REQ;
                else if (accept_c) state_d = LOOKUP;
                else               state_d = IDLE;
            end
            MISS_REQ:  if (bus.mem_req_ready) state_d = MISS_WAIT;
            MISS_WAIT: if (bus.mem_resp_valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = ready_c;
        bus.resp_valid    = 1'b0;
        bus.resp_data     = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.ram_addr      = '0;
        bus.ram_wdata     = '0;
        bus.ram_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) bus.ram_addr = bus.req_addr[7:3];
            end
            LOOKUP: begin
                if (hit_c) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = addr_q[2] ? bus.ram_rdata[LINE_W-1:WORD_W]
                                               : bus.ram_rdata[WORD_W-1:0];
                end
                if (accept_c) bus.ram_addr = bus.req_addr[7:3];
            end
            MISS_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {addr_q[31:3], 3'b000};
            end
            MISS_WAIT: begin
                if (bus.mem_resp_valid) begin
                    bus.ram_we     = 1'b1;
                    bus.ram_addr   = idx_c;
                    bus.ram_wdata  = bus.mem_resp_data;
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = addr_q[2] ? bus.mem_resp_data[LINE_W-1:WORD_W]
                                               : bus.mem_resp_data[WORD_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Request address, valid bits and flush bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q          <= '0;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            if (accept_c) addr_q <= bus.req_addr[31:2];
            if (flush_clr_c)   valid_q        <= '0;
            else if (refill_c) valid_q[idx_c] <= 1'b1;
            if (bus.flush)        flush_pending_q <= 1'b1;
            else if (flush_clr_c) flush_pending_q <= 1'b0;
        end
    end

    // Tags are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (refill_c) tag_q[idx_c] <= tag_c;
    end

`ifdef YSYX_22051013_ICACHE_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit_c) hit_cnt  <= hit_cnt + 32'd1;
            else       miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22051013_icache_ctrl.sv
// Directed bench for ysyx_22051013_icache_ctrl with a behavioural 32 x 64 synchronous data RAM.
module tb_ysyx_22051013_icache_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22051013_icache_ctrl_if bus ();

`ifdef YSYX_22051013_ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    ysyx_22051013_icache_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef YSYX_22051013_ICACHE_STAT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    logic [63:0] ram_q [32];
    always @(posedge clk) begin
        if (bus.ram_we) ram_q[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram_q[bus.ram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [63:0] line;
        int          stall;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [10];

    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input logic [63:0] line,
                         input int stall, input logic [31:0] exp_data);
        logic [31:0] line_addr;
        logic [4:0]  idx;
        line_addr = {addr[31:3], 3'b000};
        idx       = addr[7:3];
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        #1;
        chk("accept_ready", bus.req_ready, 1'b1);
        chk("accept_ram_addr", bus.ram_addr, idx);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        if (exp_hit) begin
            exp_hits++;
            chk("hit_resp_valid", bus.resp_valid, 1'b1);
            chk("hit_resp_data", bus.resp_data, exp_data);
            chk("hit_no_mem_req", bus.mem_req_valid, 1'b0);
        end else begin
            exp_miss++;
            chk("miss_no_resp", bus.resp_valid, 1'b0);
            chk("miss_ready_low", bus.req_ready, 1'b0);
            @(negedge clk);
            #1;
            for (int i = 0; i < stall; i++) begin
                chk("stall_mem_req_valid", bus.mem_req_valid, 1'b1);
                chk("stall_mem_req_addr", bus.mem_req_addr, line_addr);
                chk("stall_req_ready", bus.req_ready, 1'b0);
                @(negedge clk);
                #1;
            end
            bus.mem_req_ready = 1'b1;
            chk("mem_req_valid", bus.mem_req_valid, 1'b1);
            chk("mem_req_addr", bus.mem_req_addr, line_addr);
            @(negedge clk);
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = line;
            #1;
            chk("refill_resp_valid", bus.resp_valid, 1'b1);
            chk("refill_resp_data", bus.resp_data, exp_data);
            chk("refill_ram_we", bus.ram_we, 1'b1);
            chk("refill_ram_addr", bus.ram_addr, idx);
            chk("refill_ram_wdata", bus.ram_wdata, line);
            chk("refill_no_mem_req", bus.mem_req_valid, 1'b0);
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
            #1;
            chk("post_refill_resp", bus.resp_valid, 1'b0);
            chk("post_refill_we", bus.ram_we, 1'b0);
            chk("post_refill_ready", bus.req_ready, 1'b1);
        end
    endtask

    initial begin
        vecs[0] = '{32'h8000_0004, 1'b0, 64'h1111_2222_3333_4444, 0, 32'h1111_2222};
        vecs[1] = '{32'h8000_0000, 1'b1, 64'h0,                   0, 32'h3333_4444};
        vecs[2] = '{32'h8000_0004, 1'b1, 64'h0,                   0, 32'h1111_2222};
        vecs[3] = '{32'h8000_0100, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 32'hCCCC_DDDD};
        vecs[4] = '{32'h8000_0000, 1'b0, 64'h1111_2222_3333_4444, 0, 32'h3333_4444};
        vecs[5] = '{32'h8000_0048, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 2, 32'hCAFE_F00D};
        vecs[6] = '{32'h8000_004C, 1'b1, 64'h0,                   0, 32'hDEAD_BEEF};
        vecs[7] = '{32'h0000_00F8, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 32'h89AB_CDEF};
        vecs[8] = '{32'h0000_00FC, 1'b1, 64'h0,                   0, 32'h0123_4567};
        vecs[9] = '{32'h8000_0204, 1'b0, 64'h5555_6666_7777_8888, 5, 32'h5555_6666};

        rst_n              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        #12;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
        chk("rst_ram_we", bus.ram_we, 1'b0);
        chk("rst_ram_addr", bus.ram_addr, 5'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 64'h0);
`ifdef YSYX_22051013_ICACHE_STAT_EN
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            fetch(vecs[i].addr, vecs[i].hit, vecs[i].line, vecs[i].stall, vecs[i].data);

        // Back-to-back hits on line 0 (tag 0x800002).
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0200;
        #1;
        chk("b2b_accept0", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_addr = 32'h8000_0204;
        #1;
        chk("b2b_resp0_valid", bus.resp_valid, 1'b1);
        chk("b2b_resp0_data", bus.resp_data, 32'h7777_8888);
        chk("b2b_ready_on_hit", bus.req_ready, 1'b1);
        chk("b2b_ram_addr", bus.ram_addr, 5'd0);
        chk("b2b_no_mem_req0", bus.mem_req_valid, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("b2b_resp1_valid", bus.resp_valid, 1'b1);
        chk("b2b_resp1_data", bus.resp_data, 32'h5555_6666);
        chk("b2b_no_mem_req1", bus.mem_req_valid, 1'b0);
        exp_hits += 2;
        @(negedge clk);
        #1;
        chk("b2b_idle_resp", bus.resp_valid, 1'b0);
        chk("b2b_idle_ready", bus.req_ready, 1'b1);

        // Flush and request together in IDLE: flush wins.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_004C;
        bus.flush     = 1'b1;
        #1;
        chk("flush_acc_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush_clr_ready", bus.req_ready, 1'b0);
        chk("flush_clr_resp", bus.resp_valid, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("flush_done_ready", bus.req_ready, 1'b1);
        fetch(32'h8000_004C, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 0, 32'hDEAD_BEEF);

        // Flush during MISS_WAIT: refill completes, then a one-cycle clear.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_00F8;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("fmw_lookup_miss", bus.resp_valid, 1'b0);
        exp_miss++;
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        #1;
        chk("fmw_mem_req", bus.mem_req_valid, 1'b1);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        bus.flush         = 1'b1;
        #1;
        chk("fmw_wait_resp", bus.resp_valid, 1'b0);
        chk("fmw_wait_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        bus.flush          = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("fmw_refill_valid", bus.resp_valid, 1'b1);
        chk("fmw_refill_data", bus.resp_data, 32'h89AB_CDEF);
        chk("fmw_refill_we", bus.ram_we, 1'b1);
        chk("fmw_refill_addr", bus.ram_addr, 5'd31);
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        bus.req_valid      = 1'b1;
        bus.req_addr       = 32'h0000_00F8;
        #1;
        chk("fmw_clr_ready", bus.req_ready, 1'b0);
        chk("fmw_clr_resp", bus.resp_valid, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("fmw_after_ready", bus.req_ready, 1'b1);
        fetch(32'h0000_00F8, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 32'h89AB_CDEF);

`ifdef YSYX_22051013_ICACHE_STAT_EN
        chk("stat_hit_cnt", hit_cnt, 32'(exp_hits));
        chk("stat_miss_cnt", miss_cnt, 32'(exp_miss));
`endif

        // Reset in MISS_WAIT with a response arriving, then a stray response afterwards.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0004;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        #1;
        chk("rmw_mem_req", bus.mem_req_valid, 1'b1);
        @(negedge clk);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h9999_8888_7777_6666;
        rst_n              = 1'b0;
        #1;
        chk("rmw_rst_resp", bus.resp_valid, 1'b0);
        chk("rmw_rst_we", bus.ram_we, 1'b0);
        chk("rmw_rst_mem_req", bus.mem_req_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rmw_stray_resp", bus.resp_valid, 1'b0);
        chk("rmw_stray_we", bus.ram_we, 1'b0);
        chk("rmw_stray_ram_addr", bus.ram_addr, 5'd0);
        chk("rmw_stray_ready", bus.req_ready, 1'b1);
`ifdef YSYX_22051013_ICACHE_STAT_EN
        chk("rmw_hit_cnt", hit_cnt, 32'h0);
        chk("rmw_miss_cnt", miss_cnt, 32'h0);
`endif
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        exp_hits = 0;
        exp_miss = 0;
        fetch(32'h8000_0004, 1'b0, 64'h1111_2222_3333_4444, 0, 32'h1111_2222);
        fetch(32'h8000_0000, 1'b1, 64'h0, 0, 32'h3333_4444);
`ifdef YSYX_22051013_ICACHE_STAT_EN
        chk("end_hit_cnt", hit_cnt, 32'(exp_hits));
        chk("end_miss_cnt", miss_cnt, 32'(exp_miss));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
